vliw_sequencer: RTL and testbench
=================================

# vliw_sequencer

Program sequencer for the VLIW escape-time datapath. Holds a small microprogram of VLIW bundles and issues one bundle per cycle to the datapath's load/neg/add/mul slots. Runs an init section once, then repeats a loop body until the datapath reports escape or the iteration cap is reached. Reports `done` and the iteration count back to the host-side pixel scheduler.

## Interface

**Parameters**
- `PROG_DEPTH`, default 64: bundle slots in program memory.
- `PA_W`, default 6: program address width; `PROG_DEPTH = 2**PA_W`.
- `PIPE_LAT`, default 3: drain cycles after the last body bundle, before `escape` is sampled.
- `INSTR_W`, default 121: bundle width. Fields, MSB first:
  - load: en 1, value 27, dest 10
  - neg: en 1, src 10, dest 10
  - add: en 1, src1 10, src2 10, dest 10
  - mul: en 1, src1 10, src2 10, dest 10

**Ports**
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `prog_we` in 1: program write strobe.
- `prog_addr` in PA_W: program write address.
- `prog_wdata` in INSTR_W: bundle to write.
- `loop_start`, `loop_end` in PA_W: first and last body addresses, inclusive. Init section is `[0, loop_start)`.
- `max_iterations` in 10: iteration cap.
- `start` in 1: begin run; sampled in IDLE or DONE only.
- `escape` in 1: datapath escape flag; sampled only in CHECK.
- `busy` out 1: high from INIT through CHECK.
- `done` out 1: level, high in DONE.
- `num_iterations` out 10: completed body passes; valid while `done`.
- `cfg_err` out 1: one-cycle pulse on a rejected start.
- `wr_rejected` out 1: one-cycle pulse on a dropped program write.
- `load_enable`, `load_value`[27], `load_dest_addr`[10]: load-slot outputs.
- `neg_enable`, `neg_src_addr`, `neg_dest_addr`: neg-slot outputs.
- `add_enable`, `add_src1_addr`, `add_src2_addr`, `add_dest_addr`: add-slot outputs.
- `mul_enable`, `mul_src1_addr`, `mul_src2_addr`, `mul_dest_addr`: mul-slot outputs.

## Operation

- **States:** IDLE, INIT, BODY, DRAIN, CHECK, DONE.
- **IDLE / DONE + start:**
  - `loop_start > loop_end` → stay in current state, pulse `cfg_err`.
  - Otherwise clear the iteration counter and `pc = 0`. Go to INIT, or straight to BODY with `pc = loop_start` when `loop_start == 0`.
- **INIT:** issue `mem[pc]`, `pc++`. After issuing `loop_start-1`, go to BODY with `pc = loop_start`.
- **BODY:** issue `mem[pc]`. At `pc == loop_end`: increment iter, load the drain counter with PIPE_LAT, go to DRAIN. Otherwise `pc++`.
- **DRAIN:** issue nothing. When the counter expires, go to CHECK.
- **CHECK:** issue nothing.
  - `escape` or `iter >= max_iterations` → DONE.
  - Otherwise → BODY with `pc = loop_start`.
  - `max_iterations == 0` therefore behaves as 1.
- **DONE:** `done = 1`; `num_iterations` holds iter. A new `start` restarts the run.
- **Issue gating:**
  - In non-issue cycles, all four enables and all slot fields are driven 0.
  - In issue cycles, the fields are driven from the bundle unmodified. The enable bits in the bundle gate the slots.
- **Program writes:**
  - Accepted in IDLE and DONE.
  - In any other state they are dropped and `wr_rejected` pulses.
  - Program memory is not cleared by reset.
- **Iteration counter:** 10 bits and saturates at 1023. It cannot exceed the cap, so no wrap occurs.
- **Reset mid-run:** next cycle is IDLE. All outputs are 0, and pending drain and iteration state is discarded.
- **start in other states:** ignored while busy. `start` and `prog_we` in the same IDLE cycle: the write lands, and the run fetches the new contents.

## Timing

- **Output registers:** all outputs are registered. Reset values are 0 for `busy`, `done`, `num_iterations`, `cfg_err`, `wr_rejected`, all enables, and all fields.
- **Start latency:** with `start` sampled at edge E0, the first bundle is on the outputs for the cycle after edge E1. `busy` rises after E0.
- **Issue order:** bundles are issued back-to-back, one per cycle, with no bubbles inside INIT→BODY or within BODY.
- **Per-pass overhead:** between the last body bundle and the next pass's first bundle there are PIPE_LAT drain cycles plus 1 CHECK cycle.
- **Run length:** from the first bundle issued to `done` rising = `L_init + n·(L_body + PIPE_LAT + 1)` cycles, where n = passes.
- **escape sampling:** `escape` is sampled on the CHECK cycle's edge only. Pulses outside CHECK are ignored.

## Test plan

- **Basic run:** load 4 bundles; `loop_start=1`, `loop_end=2`, `max_iterations=5`, `escape=0`, start.
  - Required: issue sequence 0,1,2,[3 idle],[1 CHECK],1,2,… for 5 passes.
  - Required: `done=1`, `num_iterations=5`, address 3 never issued.
- **Early escape:** same program, `escape` held high from the start.
  - Required: exactly one pass, `num_iterations=1`.
  - Also: `escape` pulsed only in a DRAIN cycle is ignored.
- **Cap edge cases:**
  - `max_iterations=0` → 1 pass.
  - `loop_start=0`, `loop_end=0` → 1-bundle body, no INIT cycles.
  - `max_iterations=1023` → `num_iterations=1023`.
- **Config and write errors:**
  - `loop_start=5`, `loop_end=3` + start → `cfg_err` single pulse, `busy` stays 0.
  - `prog_we` while busy → `wr_rejected` pulse; the memory word is unchanged after the run.
- **Reset mid-BODY:** reset asserted for one cycle.
  - Required: next cycle all enables 0, `busy=0`, `done=0`.
  - Required: a new start replays the program, which was retained across reset, identically.
- **Enable gating:** a bundle with only `mul_en=1`.
  - Required: `mul_enable=1` and the other slot enables 0 that cycle.
  - Required: all fields 0 during DRAIN and CHECK.

Source files
------------

// File: rtl/vliw_sequencer.sv
// Purpose : microprogram sequencer issuing one VLIW bundle per cycle; init once, loop body until escape/cap.
// Latency : start sampled at E0 -> first bundle on outputs after E1; all outputs registered.
// Backpr. : none; program writes outside IDLE/DONE are dropped (wr_rejected), bad loop bounds pulse cfg_err.
//
// Ports: clk/reset (sync, active-high); prog_we/prog_addr/prog_wdata program load;
// loop_start/loop_end/max_iterations run config; start/escape control; busy/done/num_iterations
// status; cfg_err/wr_rejected error pulses; load/neg/add/mul slot outputs.
module vliw_sequencer #(
    parameter int PROG_DEPTH = 64,
    parameter int PA_W       = 6,
    parameter int PIPE_LAT   = 3,
    parameter int INSTR_W    = 121
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               prog_we,
    input  logic [PA_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_wdata,
    input  logic [PA_W-1:0]    loop_start,
    input  logic [PA_W-1:0]    loop_end,
    input  logic [9:0]         max_iterations,
    input  logic               start,
    input  logic               escape,
    output logic               busy,
    output logic               done,
    output logic [9:0]         num_iterations,
    output logic               cfg_err,
    output logic               wr_rejected,
    output logic               load_enable,
    output logic [26:0]        load_value,
    output logic [9:0]         load_dest_addr,
    output logic               neg_enable,
    output logic [9:0]         neg_src_addr,
    output logic [9:0]         neg_dest_addr,
    output logic               add_enable,
    output logic [9:0]         add_src1_addr,
    output logic [9:0]         add_src2_addr,
    output logic [9:0]         add_dest_addr,
    output logic               mul_enable,
    output logic [9:0]         mul_src1_addr,
    output logic [9:0]         mul_src2_addr,
    output logic [9:0]         mul_dest_addr
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_BODY  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int CNT_W = $clog2(PIPE_LAT + 2);

    logic [INSTR_W-1:0] prog_mem [PROG_DEPTH];

    logic [2:0]         state_q, state_d;
    logic [PA_W-1:0]    pc_q, pc_d;
    logic [9:0]         iter_q, iter_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [INSTR_W-1:0] bundle_q, bundle_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [9:0]         num_q, num_d;
    logic               cfg_err_q, cfg_err_d;
    logic               wr_rej_q, wr_rej_d;
    logic               mem_we;
    logic               issue;
    logic               idle_like;
    logic [PA_W-1:0]    pc_inc;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        iter_d    = iter_q;
        cnt_d     = cnt_q;
        cfg_err_d = 1'b0;
        wr_rej_d  = 1'b0;
        mem_we    = 1'b0;
        issue     = 1'b0;
        pc_inc    = pc_q + 1'b1;
        idle_like = (state_q == S_IDLE) || (state_q == S_DONE);

        if (prog_we) begin
            if (idle_like) mem_we = 1'b1;
            else           wr_rej_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (loop_start > loop_end) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        iter_d = '0;
                        if (loop_start == '0) begin
                            state_d = S_BODY;
                            pc_d    = loop_start;
                        end else begin
                            state_d = S_INIT;
                            pc_d    = '0;
                        end
                    end
                end
            end
            S_INIT: begin
                issue = 1'b1;
                if (pc_inc == loop_start) begin
                    state_d = S_BODY;
                    pc_d    = loop_start;
                end else begin
                    pc_d = pc_inc;
                end
            end
            S_BODY: begin
                issue = 1'b1;
                if (pc_q == loop_end) begin
                    // saturation is belt-and-braces: the cap check stops us first
                    iter_d = (iter_q == 10'h3FF) ? iter_q : iter_q + 10'd1;
                    cnt_d  = CNT_W'(PIPE_LAT);
                    state_d = (PIPE_LAT == 0) ? S_CHECK : S_DRAIN;
                end else begin
                    pc_d = pc_inc;
                end
            end
            S_DRAIN: begin
                if (cnt_q <= CNT_W'(1)) state_d = S_CHECK;
                else                    cnt_d = cnt_q - 1'b1;
            end
            S_CHECK: begin
                // iter is at least 1 here, so a cap of 0 acts like 1
                if (escape || (iter_q >= max_iterations)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_BODY;
                    pc_d    = loop_start;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // outputs trail the state by one cycle, so done waits one cycle after DONE is entered
        bundle_d = issue ? prog_mem[pc_q] : '0;
        busy_d   = (state_d == S_INIT) || (state_d == S_BODY) ||
                   (state_d == S_DRAIN) || (state_d == S_CHECK);
        done_d   = (state_q == S_DONE) && (state_d == S_DONE);
        num_d    = done_d ? iter_q : '0;
    end

    // program memory is deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we) prog_mem[prog_addr] <= prog_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            iter_q    <= '0;
            cnt_q     <= '0;
            bundle_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            num_q     <= '0;
            cfg_err_q <= 1'b0;
            wr_rej_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            iter_q    <= iter_d;
            cnt_q     <= cnt_d;
            bundle_q  <= bundle_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            num_q     <= num_d;
            cfg_err_q <= cfg_err_d;
            wr_rej_q  <= wr_rej_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign num_iterations = num_q;
    assign cfg_err        = cfg_err_q;
    assign wr_rejected    = wr_rej_q;

    assign load_enable    = bundle_q[120];
    assign load_value     = bundle_q[119:93];
    assign load_dest_addr = bundle_q[92:83];
    assign neg_enable     = bundle_q[82];
    assign neg_src_addr   = bundle_q[81:72];
    assign neg_dest_addr  = bundle_q[71:62];
    assign add_enable     = bundle_q[61];
    assign add_src1_addr  = bundle_q[60:51];
    assign add_src2_addr  = bundle_q[50:41];
    assign add_dest_addr  = bundle_q[40:31];
    assign mul_enable     = bundle_q[30];
    assign mul_src1_addr  = bundle_q[29:20];
    assign mul_src2_addr  = bundle_q[19:10];
    assign mul_dest_addr  = bundle_q[9:0];
endmodule

// File: tb/tb_vliw_sequencer.sv
module tb_vliw_sequencer;
    localparam int PIPE_LAT = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         prog_we;
    logic [5:0]   prog_addr;
    logic [120:0] prog_wdata;
    logic [5:0]   loop_start, loop_end;
    logic [9:0]   max_iterations;
    logic         start, escape;
    logic         busy, done, cfg_err, wr_rejected;
    logic [9:0]   num_iterations;
    logic         load_enable, neg_enable, add_enable, mul_enable;
    logic [26:0]  load_value;
    logic [9:0]   load_dest_addr, neg_src_addr, neg_dest_addr;
    logic [9:0]   add_src1_addr, add_src2_addr, add_dest_addr;
    logic [9:0]   mul_src1_addr, mul_src2_addr, mul_dest_addr;

    logic [120:0] out_vec;
    logic [120:0] tb_mem [64];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vliw_sequencer dut (
        .clk(clk), .reset(reset),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .loop_start(loop_start), .loop_end(loop_end), .max_iterations(max_iterations),
        .start(start), .escape(escape),
        .busy(busy), .done(done), .num_iterations(num_iterations),
        .cfg_err(cfg_err), .wr_rejected(wr_rejected),
        .load_enable(load_enable), .load_value(load_value), .load_dest_addr(load_dest_addr),
        .neg_enable(neg_enable), .neg_src_addr(neg_src_addr), .neg_dest_addr(neg_dest_addr),
        .add_enable(add_enable), .add_src1_addr(add_src1_addr), .add_src2_addr(add_src2_addr),
        .add_dest_addr(add_dest_addr),
        .mul_enable(mul_enable), .mul_src1_addr(mul_src1_addr), .mul_src2_addr(mul_src2_addr),
        .mul_dest_addr(mul_dest_addr)
    );

    assign out_vec = {load_enable, load_value, load_dest_addr,
                      neg_enable, neg_src_addr, neg_dest_addr,
                      add_enable, add_src1_addr, add_src2_addr, add_dest_addr,
                      mul_enable, mul_src1_addr, mul_src2_addr, mul_dest_addr};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [120:0] bundle_of(input int a);
        return {1'b1, 27'(32'h1000 + a), 10'(a + 1),
                1'b1, 10'(a + 20), 10'(a + 40),
                1'b0, 10'(a + 60), 10'(a + 80), 10'(a + 100),
                1'b1, 10'(a + 120), 10'(a + 140), 10'(a + 160)};
    endfunction

    task automatic wr(input int a, input logic [120:0] d);
        prog_we = 1'b1; prog_addr = 6'(a); prog_wdata = d;
        step();
        prog_we = 1'b0;
        tb_mem[a] = d;
        chk("wr_accepted", {127'b0, wr_rejected}, 128'd0);
    endtask

    // Starts a run from IDLE/DONE and checks every output cycle against a
    // hand-built issue sequence (-1 = idle cycle), then done/num_iterations.
    task automatic run_trace(input int ls, input int le, input int mi,
                             input bit esc_hold, input int pulse_idx, input string tag);
        int q[$];
        int n;
        n = esc_hold ? 1 : ((mi == 0) ? 1 : mi);
        for (int a = 0; a < ls; a++) q.push_back(a);
        for (int p = 0; p < n; p++) begin
            for (int a = ls; a <= le; a++) q.push_back(a);
            for (int k = 0; k <= PIPE_LAT; k++) q.push_back(-1);
        end
        loop_start = 6'(ls); loop_end = 6'(le); max_iterations = 10'(mi);
        escape = esc_hold;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_busy_rise"}, {127'b0, busy}, 128'd1);
        chk({tag, "_done_low"},  {127'b0, done}, 128'd0);
        for (int i = 0; i < q.size(); i++) begin
            step();
            escape = esc_hold || (i == pulse_idx);
            if (q[i] < 0) chk({tag, "_idle"}, {7'b0, out_vec}, 128'd0);
            else          chk({tag, "_issue"}, {7'b0, out_vec}, {7'b0, tb_mem[q[i]]});
        end
        escape = 1'b0;
        step();
        chk({tag, "_done"},  {127'b0, done}, 128'd1);
        chk({tag, "_busy"},  {127'b0, busy}, 128'd0);
        chk({tag, "_niter"}, {118'b0, num_iterations}, 128'(n));
    endtask

    initial begin
        reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        loop_start = '0; loop_end = '0; max_iterations = '0;
        start = 1'b0; escape = 1'b0;
        for (int i = 0; i < 64; i++) tb_mem[i] = '0;
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_out",  {7'b0, out_vec}, 128'd0);
        chk("rst_busy", {127'b0, busy}, 128'd0);
        chk("rst_done", {127'b0, done}, 128'd0);
        chk("rst_niter", {118'b0, num_iterations}, 128'd0);
        chk("rst_errs", {126'b0, cfg_err, wr_rejected}, 128'd0);

        for (int a = 0; a < 4; a++) wr(a, bundle_of(a));

        // basic: 0,1,2,[4 idle],1,2,... five passes, addr 3 never issued
        run_trace(1, 2, 5, 1'b0, -1, "basic");
        // escape held high: single pass
        run_trace(1, 2, 5, 1'b1, -1, "esc_hold");
        // escape pulsed during DRAIN of pass 1 only: ignored
        run_trace(1, 2, 2, 1'b0, 2, "esc_drain");
        // cap of 0 behaves as 1
        run_trace(1, 2, 0, 1'b0, -1, "cap0");
        // single-bundle body, no init
        run_trace(0, 0, 3, 1'b0, -1, "ls0");
        // full cap
        run_trace(0, 0, 1023, 1'b0, -1, "cap1023");

        // rejected program write while busy
        loop_start = 6'd1; loop_end = 6'd2; max_iterations = 10'd1;
        start = 1'b1; step(); start = 1'b0;
        prog_we = 1'b1; prog_addr = 6'd3; prog_wdata = ~tb_mem[3];
        step();
        prog_we = 1'b0;
        chk("wr_rej_pulse", {127'b0, wr_rejected}, 128'd1);
        step();
        chk("wr_rej_clear", {127'b0, wr_rejected}, 128'd0);
        for (int k = 0; k < 50 && !done; k++) step();
        chk("wr_rej_run_done", {127'b0, done}, 128'd1);
        // addr 3 must still hold its original contents
        run_trace(3, 3, 1, 1'b0, -1, "mem_kept");

        // reset in the middle of BODY
        loop_start = 6'd1; loop_end = 6'd2; max_iterations = 10'd5;
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        reset = 1'b1; step(); reset = 1'b0;
        chk("midrst_out",  {7'b0, out_vec}, 128'd0);
        chk("midrst_busy", {127'b0, busy}, 128'd0);
        chk("midrst_done", {127'b0, done}, 128'd0);

        // bad loop bounds from IDLE
        loop_start = 6'd5; loop_end = 6'd3;
        start = 1'b1; step(); start = 1'b0;
        chk("cfg_err_pulse", {127'b0, cfg_err}, 128'd1);
        chk("cfg_err_busy",  {127'b0, busy}, 128'd0);
        step();
        chk("cfg_err_clear", {127'b0, cfg_err}, 128'd0);
        chk("cfg_err_busy2", {127'b0, busy}, 128'd0);

        // program retained across reset replays identically
        run_trace(1, 2, 2, 1'b0, -1, "replay");

        // enable gating: only mul slot enabled in body bundle
        wr(4, {1'b0, 27'd0, 10'd0, 1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0, 10'd0,
               1'b1, 10'h11, 10'h22, 10'h33});
        run_trace(4, 4, 2, 1'b0, -1, "mul_only");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
